seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parametrised, runtime-programmable serial pattern detector. It succeeds the fixed 1011 Moore detector.
- Pattern length from 1 to MAX_LEN is supported. Pattern and length are loadable at runtime, overlap or non-overlap mode is selectable, and a valid-qualified input and a saturating match counter are provided.
- Sits on the serial bit stream ahead of frame-sync and control logic. Powers up detecting 1011 with overlap, so it drops in for the fixed detector.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..32).
- LEN_W, $clog2(MAX_LEN+1), width of the length field.
- CNT_W, 8, match counter width.
- DEF_PAT, 'b1011, pattern loaded at reset (right-aligned).
- DEF_LEN, 4, pattern length loaded at reset.

Ports:
- clk  in  1  rising-edge clock. One clock domain; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high reset.
- x_valid  in  1  x is sampled only when this is high.
- x  in  1  serial data bit.
- overlap_en  in  1  1 = overlapping matches allowed; 0 = history cleared after each match.
- pat_load  in  1  one-cycle strobe that loads pat_in/len_in.
- pat_in  in  MAX_LEN  pattern, right-aligned. Bit len-1 is the first bit received; bit 0 is the last.
- len_in  in  LEN_W  pattern length.
- cnt_clr  in  1  clears match_cnt.
- y  out  1  Moore match flag, registered.
- match_cnt  out  CNT_W  number of matches, saturating.
- cfg_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- **Reset** (reset=1 at a clk edge) sets:
  - pat_r=DEF_PAT, len_r=DEF_LEN
  - hist=0, fill=0
  - y=0, match_cnt=0, cfg_err=0
- **State:**
  - hist[MAX_LEN-1:0] is the history shift register.
  - fill (LEN_W bits) counts valid history bits and saturates at len_r.
- **Shift:** on x_valid=1, hist <= {hist[MAX_LEN-2:0], x} and fill <= min(fill+1, len_r). When x_valid=0, hist, fill and y hold their values, except that y clears (next bullet).
- **Match:**
  - Definition: the bit accepted this cycle completes a match when next_fill==len_r and (next_hist & mask)==(pat_r & mask), where mask = low len_r bits set.
  - Output: y is registered high for exactly the cycle after the completing bit (Moore, one-cycle latency). y is 0 in every other cycle, including cycles with x_valid=0.
- **Overlap mode:**
  - overlap_en=1: history is kept after a match, so a suffix can start the next match.
  - overlap_en=0: on a match cycle, fill <= 0 and hist <= 0 instead of the shifted values.
  - overlap_en is sampled every cycle; a change takes effect on the next accepted bit.
- **Load:**
  - pat_load=1 with 1<=len_in<=MAX_LEN: pat_r<=pat_in, len_r<=len_in, hist<=0, fill<=0, y<=0.
  - len_in=0 or len_in>MAX_LEN: load ignored, config unchanged, cfg_err=1 for one cycle.
- **Simultaneous load and bit:** pat_load and x_valid in the same cycle means the load wins and that bit is discarded. This applies even if the load is rejected.
- **Counter:**
  - match_cnt increments on each match cycle and saturates at 2^CNT_W-1 (no wrap).
  - cnt_clr=1 alone gives 0. cnt_clr=1 together with a match gives 1.
- **Priority:** reset > pat_load > x_valid shift/match. cnt_clr is independent of pat_load.
- **Reset mid-stream:** partial history is discarded and a runtime-loaded pattern reverts to DEF_PAT/DEF_LEN.
- **len_r=1:** every accepted bit equal to pat_r[0] is a match, in both modes.
- **Implementation constraints:** no combinational path from inputs to outputs. All outputs are registered.

Decomposition:
- **Package seq_det_pkg** holds:
  - MAX_LEN_DEF, CNT_W_DEF, DEF_PAT_1011, DEF_LEN_4
  - a function len_mask(len) returning a MAX_LEN-bit mask
  - a function len_ok(len) implementing the legality check
- **One sub-module, sat_counter** (parameter W; inputs clk, reset, inc, clr; output cnt), implementing the saturate and clear/inc rules above. The top level holds the config registers, history, fill and match logic.

Test Plan:
1. Default 1011, overlap_en=1, x=1,0,1,1,0,1,1 on consecutive valid cycles -> y high in the cycles after bits 4 and 7; match_cnt=2.
2. Same stream with overlap_en=0 -> y only after bit 4; match_cnt=1; fill=3 after bit 7.
3. pat_load pat_in=8'b1110_0101, len_in=8, then feed 11100101 with x_valid toggling 1/0 between bits -> single y pulse after the 8th valid bit; gaps do not break the match. Then pat_load len_in=0 -> cfg_err pulse; len_r stays 8.
4. Feed 1,0,1 then reset=1 for one cycle, then 1 -> no y; feed 0,1,1 -> y after the last 1. Separately, pat_load coincident with x_valid -> that bit is ignored (verify fill=0).
5. CNT_W=2, len 1, pattern 1, stream of 5 ones -> match_cnt 1,2,3,3,3. Then cnt_clr with a simultaneous match -> match_cnt=1; cnt_clr alone -> 0.
6. Random stream of 10k bits with random loads, modes and valid gaps, checked against a reference-model scoreboard -> y and match_cnt agree every cycle.

Source files
------------

// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared constants and helpers for the programmable serial pattern detector.
//   MAX_LEN_DEF  : default maximum pattern length
//   CNT_W_DEF    : default match counter width
//   DEF_PAT_1011 : power-up pattern (right-aligned), matches the fixed detector
//   DEF_LEN_4    : power-up pattern length
//   len_mask()   : mask with the low 'len' bits set (32 bits, caller narrows)
//   len_ok()     : legality check for a runtime length load
// -----------------------------------------------------------------------------
package seq_det_pkg;

  localparam int          MAX_LEN_DEF  = 8;
  localparam int          CNT_W_DEF    = 8;
  localparam logic [31:0] DEF_PAT_1011 = 32'h0000_000B;
  localparam int          DEF_LEN_4    = 4;

  // Low 'len' bits set; MAX_LEN never exceeds 32 so 32 bits always suffice.
  function automatic logic [31:0] len_mask(input int unsigned len);
    logic [31:0] m;
    m = 32'h0000_0000;
    for (int unsigned i = 0; i < 32; i++) begin
      m[i] = (i < len);
    end
    return m;
  endfunction

  // A length is usable when it is non-zero and fits the history register.
  function automatic logic len_ok(input int unsigned len, input int unsigned max_len);
    return (len >= 32'd1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, clears the count
//   inc   : count one event this cycle
//   clr   : clear the count; an inc in the same cycle leaves the count at 1
//   cnt   : registered count, sticks at all-ones instead of wrapping
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX_V  = {W{1'b1}};
  localparam logic [W-1:0] ZERO_V = {W{1'b0}};
  localparam logic [W-1:0] ONE_V  = W'(1);

  // Count register: clear has priority over increment, increment saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= ZERO_V;
    end else if (clr) begin
      cnt <= inc ? ONE_V : ZERO_V;
    end else if (inc && (cnt != MAX_V)) begin
      cnt <= cnt + ONE_V;
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
// Runtime-programmable serial pattern detector (Moore, one-cycle latency).
// Powers up looking for 1011 with overlap so it drops in for the fixed detector.
//   clk        : rising-edge clock
//   reset      : synchronous active-high reset (restores DEF_PAT/DEF_LEN)
//   x_valid    : qualifies x; bits with x_valid=0 are ignored
//   x          : serial data bit
//   overlap_en : 1 keeps history after a match, 0 clears it
//   pat_load   : one-cycle strobe loading pat_in/len_in (wins over x_valid)
//   pat_in     : pattern, right-aligned, bit len-1 is received first
//   len_in     : pattern length, legal range 1..MAX_LEN
//   cnt_clr    : clears match_cnt (a simultaneous match leaves it at 1)
//   y          : registered match flag, high the cycle after a completing bit
//   match_cnt  : saturating match count
//   cfg_err    : one-cycle pulse when a load is rejected
// -----------------------------------------------------------------------------
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN = MAX_LEN_DEF,
  parameter int                 LEN_W   = $clog2(MAX_LEN + 1),
  parameter int                 CNT_W   = CNT_W_DEF,
  parameter logic [MAX_LEN-1:0] DEF_PAT = DEF_PAT_1011[MAX_LEN-1:0],
  parameter int                 DEF_LEN = DEF_LEN_4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x_valid,
  input  logic               x,
  input  logic               overlap_en,
  input  logic               pat_load,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LEN_W-1:0]   len_in,
  input  logic               cnt_clr,
  output logic               y,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  localparam logic [LEN_W-1:0]   LEN_ONE   = LEN_W'(1);
  localparam logic [LEN_W-1:0]   LEN_ZERO  = {LEN_W{1'b0}};
  localparam logic [MAX_LEN-1:0] HIST_ZERO = {MAX_LEN{1'b0}};

  logic [MAX_LEN-1:0] pat_r;
  logic [LEN_W-1:0]   len_r;
  logic [MAX_LEN-1:0] hist_r;
  logic [LEN_W-1:0]   fill_r;
  logic               y_r;
  logic               cfg_err_r;

  logic [MAX_LEN-1:0] next_hist_s;
  logic [LEN_W-1:0]   next_fill_s;
  logic [31:0]        mask_s;
  logic               load_ok_s;
  logic               match_s;

  // Next-state history/fill for an accepted bit and the match decision on it.
  always_comb begin
    next_hist_s = {hist_r[MAX_LEN-2:0], x};
    if (fill_r >= len_r) begin
      next_fill_s = len_r;
    end else begin
      next_fill_s = fill_r + LEN_ONE;
    end
    mask_s    = len_mask(32'(len_r));
    load_ok_s = len_ok(32'(len_in), MAX_LEN);
    // A load in the same cycle discards the bit, so it can never match.
    match_s   = x_valid && !pat_load && (next_fill_s == len_r) &&
                (((32'(next_hist_s) ^ 32'(pat_r)) & mask_s) == 32'h0000_0000);
  end

  // Config, history, fill and registered flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_r     <= DEF_PAT;
      len_r     <= LEN_W'(DEF_LEN);
      hist_r    <= HIST_ZERO;
      fill_r    <= LEN_ZERO;
      y_r       <= 1'b0;
      cfg_err_r <= 1'b0;
    end else if (pat_load) begin
      y_r       <= 1'b0;
      cfg_err_r <= !load_ok_s;
      if (load_ok_s) begin
        pat_r  <= pat_in;
        len_r  <= len_in;
        hist_r <= HIST_ZERO;
        fill_r <= LEN_ZERO;
      end else begin
        pat_r  <= pat_r;
        len_r  <= len_r;
        hist_r <= hist_r;
        fill_r <= fill_r;
      end
    end else if (x_valid) begin
      y_r       <= match_s;
      cfg_err_r <= 1'b0;
      if (match_s && !overlap_en) begin
        hist_r <= HIST_ZERO;
        fill_r <= LEN_ZERO;
      end else begin
        hist_r <= next_hist_s;
        fill_r <= next_fill_s;
      end
    end else begin
      y_r       <= 1'b0;
      cfg_err_r <= 1'b0;
      hist_r    <= hist_r;
      fill_r    <= fill_r;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (match_s),
    .clr   (cnt_clr),
    .cnt   (match_cnt)
  );

  assign y       = y_r;
  assign cfg_err = cfg_err_r;

endmodule

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_param
// Directed scenarios for the programmable detector plus a randomized stream
// compared against a queue-based reference model. A second instance with a
// 2-bit counter shares all inputs and is used for saturation behaviour.
// -----------------------------------------------------------------------------
module tb_seq_detector_param;

  logic       clk;
  logic       reset;
  logic       x_valid;
  logic       x;
  logic       overlap_en;
  logic       pat_load;
  logic [7:0] pat_in;
  logic [3:0] len_in;
  logic       cnt_clr;
  logic       y;
  logic [7:0] match_cnt;
  logic       cfg_err;
  logic       y2;
  logic [1:0] match_cnt2;
  logic       cfg_err2;

  int checks;
  int errors;

  // reference model state for the randomized test
  bit         q[$];
  int         m_len;
  logic [7:0] m_pat;
  int         m_cnt;
  bit         m_y;
  bit         m_err;

  seq_detector_param dut (
    .clk        (clk),
    .reset      (reset),
    .x_valid    (x_valid),
    .x          (x),
    .overlap_en (overlap_en),
    .pat_load   (pat_load),
    .pat_in     (pat_in),
    .len_in     (len_in),
    .cnt_clr    (cnt_clr),
    .y          (y),
    .match_cnt  (match_cnt),
    .cfg_err    (cfg_err)
  );

  seq_detector_param #(.CNT_W(2)) dut2 (
    .clk        (clk),
    .reset      (reset),
    .x_valid    (x_valid),
    .x          (x),
    .overlap_en (overlap_en),
    .pat_load   (pat_load),
    .pat_in     (pat_in),
    .len_in     (len_in),
    .cnt_clr    (cnt_clr),
    .y          (y2),
    .match_cnt  (match_cnt2),
    .cfg_err    (cfg_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    x_valid = 1'b1;
    x       = b;
    cyc();
    x_valid = 1'b0;
    x       = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l);
    pat_load = 1'b1;
    pat_in   = p;
    len_in   = l;
    cyc();
    pat_load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    checks++; if (y !== 1'b0) begin errors++; $display("FAIL reset_y: got %0b expected 0", y); end
    checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", match_cnt); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %0b expected 0", cfg_err); end
    checks++; if (dut.fill_r !== 4'd0) begin errors++; $display("FAIL reset_fill: got %0d expected 0", dut.fill_r); end
    checks++; if (dut.len_r !== 4'd4) begin errors++; $display("FAIL reset_len: got %0d expected 4", dut.len_r); end
    checks++; if (dut.pat_r !== 8'h0B) begin errors++; $display("FAIL reset_pat: got %h expected 0b", dut.pat_r); end
  endtask

  task automatic test_overlap();
    logic [6:0] bits;
    logic [6:0] exp_y;
    bits  = 7'b1011011;
    exp_y = 7'b0001001;
    do_reset();
    overlap_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send_bit(bits[6-i]);
      checks++;
      if (y !== exp_y[6-i]) begin errors++; $display("FAIL overlap_y[%0d]: got %0b expected %0b", i, y, exp_y[6-i]); end
    end
    checks++; if (match_cnt !== 8'd2) begin errors++; $display("FAIL overlap_cnt: got %0d expected 2", match_cnt); end
  endtask

  task automatic test_non_overlap();
    logic [6:0] bits;
    logic [6:0] exp_y;
    bits  = 7'b1011011;
    exp_y = 7'b0001000;
    do_reset();
    overlap_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      send_bit(bits[6-i]);
      checks++;
      if (y !== exp_y[6-i]) begin errors++; $display("FAIL nonoverlap_y[%0d]: got %0b expected %0b", i, y, exp_y[6-i]); end
    end
    checks++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL nonoverlap_cnt: got %0d expected 1", match_cnt); end
    checks++; if (dut.fill_r !== 4'd3) begin errors++; $display("FAIL nonoverlap_fill: got %0d expected 3", dut.fill_r); end
    overlap_en = 1'b1;
  endtask

  task automatic test_load_gaps();
    logic [7:0] p;
    p = 8'b1110_0101;
    do_reset();
    load(p, 4'd8);
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL load_ok_err: got %0b expected 0", cfg_err); end
    checks++; if (dut.len_r !== 4'd8) begin errors++; $display("FAIL load_len: got %0d expected 8", dut.len_r); end
    for (int i = 0; i < 8; i++) begin
      send_bit(p[7-i]);
      checks++;
      if (y !== (i == 7)) begin errors++; $display("FAIL gap_y[%0d]: got %0b expected %0b", i, y, (i == 7)); end
      cyc();
      checks++;
      if (y !== 1'b0) begin errors++; $display("FAIL gap_idle_y[%0d]: got %0b expected 0", i, y); end
    end
    checks++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL gap_cnt: got %0d expected 1", match_cnt); end
    load(8'hAA, 4'd0);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL len0_err: got %0b expected 1", cfg_err); end
    checks++; if (dut.len_r !== 4'd8) begin errors++; $display("FAIL len0_len: got %0d expected 8", dut.len_r); end
    checks++; if (dut.pat_r !== 8'hE5) begin errors++; $display("FAIL len0_pat: got %h expected e5", dut.pat_r); end
    cyc();
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_pulse: got %0b expected 0", cfg_err); end
    load(8'h55, 4'd9);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL len9_err: got %0b expected 1", cfg_err); end
    checks++; if (dut.len_r !== 4'd8) begin errors++; $display("FAIL len9_len: got %0d expected 8", dut.len_r); end
  endtask

  task automatic test_reset_mid();
    logic [2:0] tail;
    tail = 3'b011;
    // pattern E5/len 8 still loaded from the previous scenario
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    do_reset();
    checks++; if (dut.len_r !== 4'd4) begin errors++; $display("FAIL midreset_len: got %0d expected 4", dut.len_r); end
    checks++; if (dut.fill_r !== 4'd0) begin errors++; $display("FAIL midreset_fill: got %0d expected 0", dut.fill_r); end
    send_bit(1'b1);
    checks++; if (y !== 1'b0) begin errors++; $display("FAIL midreset_first_y: got %0b expected 0", y); end
    for (int i = 0; i < 3; i++) begin
      send_bit(tail[2-i]);
      checks++;
      if (y !== (i == 2)) begin errors++; $display("FAIL midreset_y[%0d]: got %0b expected %0b", i, y, (i == 2)); end
    end
    // accepted load coincident with a bit: bit discarded, history cleared
    do_reset();
    send_bit(1'b1);
    send_bit(1'b0);
    x_valid = 1'b1;
    x       = 1'b1;
    load(8'h0B, 4'd4);
    x_valid = 1'b0;
    checks++; if (dut.fill_r !== 4'd0) begin errors++; $display("FAIL loadbit_fill: got %0d expected 0", dut.fill_r); end
    checks++; if (y !== 1'b0) begin errors++; $display("FAIL loadbit_y: got %0b expected 0", y); end
    // rejected load coincident with a bit: bit still discarded
    send_bit(1'b1);
    x_valid = 1'b1;
    x       = 1'b1;
    load(8'h0B, 4'd0);
    x_valid = 1'b0;
    checks++; if (dut.fill_r !== 4'd1) begin errors++; $display("FAIL rejbit_fill: got %0d expected 1", dut.fill_r); end
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL rejbit_err: got %0b expected 1", cfg_err); end
  endtask

  task automatic test_counter_sat();
    logic [1:0] exp_c [5];
    exp_c = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    load(8'h01, 4'd1);
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    checks++; if (match_cnt2 !== 2'd0) begin errors++; $display("FAIL sat_clr0: got %0d expected 0", match_cnt2); end
    send_bit(1'b0);
    checks++; if (y2 !== 1'b0) begin errors++; $display("FAIL len1_zero_y: got %0b expected 0", y2); end
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b1);
      checks++;
      if (match_cnt2 !== exp_c[i]) begin errors++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", i, match_cnt2, exp_c[i]); end
      checks++;
      if (y2 !== 1'b1) begin errors++; $display("FAIL len1_y[%0d]: got %0b expected 1", i, y2); end
    end
    cnt_clr = 1'b1;
    send_bit(1'b1);
    cnt_clr = 1'b0;
    checks++; if (match_cnt2 !== 2'd1) begin errors++; $display("FAIL clr_with_match: got %0d expected 1", match_cnt2); end
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    checks++; if (match_cnt2 !== 2'd0) begin errors++; $display("FAIL clr_alone: got %0d expected 0", match_cnt2); end
    checks++; if (cfg_err2 !== 1'b0) begin errors++; $display("FAIL sat_cfg_err: got %0b expected 0", cfg_err2); end
  endtask

  // Reference model: one clock's worth of behaviour from the current inputs.
  task automatic model_step();
    bit hit;
    hit   = 1'b0;
    m_err = 1'b0;
    if (pat_load) begin
      if (len_in >= 4'd1 && len_in <= 4'd8) begin
        m_pat = pat_in;
        m_len = int'(len_in);
        q.delete();
      end else begin
        m_err = 1'b1;
      end
    end else if (x_valid) begin
      q.push_back(x);
      if (q.size() > m_len) void'(q.pop_front());
      if (q.size() == m_len) begin
        hit = 1'b1;
        for (int i = 0; i < m_len; i++) begin
          if (q[i] != m_pat[m_len-1-i]) hit = 1'b0;
        end
      end
      if (hit && !overlap_en) q.delete();
    end
    m_y = hit;
    if (cnt_clr) m_cnt = hit ? 1 : 0;
    else if (hit && m_cnt < 255) m_cnt = m_cnt + 1;
  endtask

  task automatic test_random();
    do_reset();
    q.delete();
    m_len = 4;
    m_pat = 8'h0B;
    m_cnt = 0;
    overlap_en = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      x_valid  = ($urandom_range(0, 3) != 0);
      x        = 1'($urandom_range(0, 1));
      pat_load = ($urandom_range(0, 99) == 0);
      pat_in   = 8'($urandom_range(0, 255));
      len_in   = 4'($urandom_range(0, 9));
      cnt_clr  = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) overlap_en = ~overlap_en;
      model_step();
      cyc();
      checks++;
      if (y !== m_y) begin errors++; $display("FAIL rand_y[%0d]: got %0b expected %0b", n, y, m_y); end
      checks++;
      if (match_cnt !== 8'(m_cnt)) begin errors++; $display("FAIL rand_cnt[%0d]: got %0d expected %0d", n, match_cnt, m_cnt); end
      checks++;
      if (cfg_err !== m_err) begin errors++; $display("FAIL rand_cfg_err[%0d]: got %0b expected %0b", n, cfg_err, m_err); end
    end
    x_valid  = 1'b0;
    pat_load = 1'b0;
    cnt_clr  = 1'b0;
    overlap_en = 1'b1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    x_valid    = 1'b0;
    x          = 1'b0;
    overlap_en = 1'b1;
    pat_load   = 1'b0;
    pat_in     = 8'h00;
    len_in     = 4'd0;
    cnt_clr    = 1'b0;
    test_reset();
    test_overlap();
    test_non_overlap();
    test_load_gaps();
    test_reset_mid();
    test_counter_sat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
